// File: rtl/mem_responder.sv
// mem_responder: fixed-latency behavioural word memory with one-cycle response pulse
module mem_responder #(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_error
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_ERR} op_t;
  state_t state, nxt;
  op_t op, live_op, c_op;
  logic [15:0] mem [MEM_WORDS];
  logic [AW-1:0] idx, c_idx;
  logic [15:0] wd, c_wd;
  logic [1:0] be, c_be;
  logic [7:0] cnt;
  logic req, go, unused_addr;
  assign unused_addr = ^mem_address;
  assign req = mem_read | mem_write;
  assign live_op = (mem_read && mem_write) ? OP_ERR : mem_write ? OP_WR : OP_RD;
  // With LATENCY=1 the commit happens on the accepting edge, so use the values being captured
  assign c_idx = (state == IDLE) ? mem_address[AW:1] : idx;
  assign c_wd = (state == IDLE) ? mem_wdata : wd;
  assign c_be = (state == IDLE) ? mem_byte_enable : be;
  assign c_op = (state == IDLE) ? live_op : op;
  assign mem_resp = state == RESP;
  assign mem_error = (state == RESP) && (op == OP_ERR);
  always_comb begin
    nxt = state;
    go = 1'b0;
    case (state)
      IDLE: if (req) begin
        nxt = (LATENCY == 1) ? RESP : BUSY;
        go = LATENCY == 1;
      end
      BUSY: if (!req) nxt = IDLE;
        else if (cnt == 8'd1) begin
          nxt = RESP;
          go = 1'b1;
        end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op <= OP_RD;
      idx <= '0;
      wd <= '0;
      be <= '0;
      mem_rdata <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        idx <= mem_address[AW:1];
        wd <= mem_wdata;
        be <= mem_byte_enable;
        op <= live_op;
        cnt <= 8'(LATENCY - 1);
      end else if (state == BUSY && req && cnt != 8'd1) cnt <= cnt - 8'd1;
      if (go && c_op == OP_RD) mem_rdata <= mem[c_idx];
      if (go && c_op == OP_WR && c_be[0]) mem[c_idx][7:0] <= c_wd[7:0];
      if (go && c_op == OP_WR && c_be[1]) mem[c_idx][15:8] <= c_wd[15:8];
    end
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the LC-3b multicycle datapath's memory interface. It accepts word read/write requests (address, write data, byte enables), models a fixed access latency, then pulses `mem_resp` for one cycle with read data or a committed write. It serves as the behavioural main memory in core-level benches and as the template for the cache's lower-level port.

## Interface
- `MEM_WORDS`, default 256: number of 16-bit words stored; power of two, 2 to 32768.
- `LATENCY`, default 4: cycles from the first request cycle to the `mem_resp` cycle; range 1 to 255.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  read request; held by the requester until `mem_resp`.
- `mem_write`  in  1  write request; held by the requester until `mem_resp`.
- `mem_byte_enable`  in  2  write byte lanes: bit0 enables [7:0], bit1 enables [15:8].
- `mem_address`  in  16  byte address; bit0 ignored; word index = `mem_address[log2(MEM_WORDS):1]`.
- `mem_wdata`  in  16  write data.
- `mem_rdata`  out  16  registered read data; valid in the `mem_resp` cycle of a read, held until the next read completes.
- `mem_resp`  out  1  one-cycle completion pulse.
- `mem_error`  out  1  high only in a `mem_resp` cycle whose request had both read and write asserted.

## Operation
- Storage: array of `MEM_WORDS` × 16-bit words. Higher address bits are dropped, so addresses wrap modulo `MEM_WORDS`.
- The FSM has three states:
  - IDLE: `mem_resp`=0. If `mem_read` or `mem_write` is high, the block:
    - captures address, wdata, byte enables, and op type (READ, WRITE, or ERR when both are high);
    - loads `cnt` = `LATENCY`−1;
    - goes to RESP if `LATENCY`=1, otherwise to BUSY.
  - BUSY: if both `mem_read` and `mem_write` are low, abort: go to IDLE with no commit and no response. Else if `cnt`==1, go to RESP. Else decrement `cnt`.
  - RESP: `mem_resp`=1, and `mem_error`=1 if op is ERR. Always returns to IDLE next cycle.
- Actions on the edge that enters RESP, using only captured values:
  - READ: `mem_rdata` ← word[index].
  - WRITE: each enabled byte lane of word[index] is written; a write with enable 00 changes nothing.
  - ERR: no array change and no `mem_rdata` change.
- Live address and data changes after acceptance are ignored.
- A request still asserted in the IDLE cycle after RESP is accepted as a new request. Requesters must drop their request on `mem_resp`.
- Reset (any state, including mid-operation):
  - state becomes IDLE and `cnt` becomes 0;
  - `mem_resp`=0, `mem_error`=0, `mem_rdata`=0x0000;
  - every memory word is cleared to 0x0000;
  - a pending access is discarded with no commit.
- `cnt` is 8 bits wide. `mem_resp` and `mem_error` are Moore outputs decoded from state and captured op.

## Timing
- Request first asserted in cycle N (FSM in IDLE) gives `mem_resp` in cycle N+`LATENCY`. Reads have `mem_rdata` valid in that same cycle.
- The write is visible to a read accepted in cycle N+`LATENCY`+1 or later.
- Back-to-back throughput: one access per `LATENCY`+1 cycles (one IDLE accept cycle between responses).
- A request arriving while the FSM is in RESP is not sampled until the following IDLE cycle.
- Abort is checked every BUSY cycle, including the final one (`cnt`==1). With `LATENCY`=1 no abort window exists.
- First cycle after reset deasserts: IDLE, all outputs 0.

## Test plan
- Reset, then read 0x0010 with `LATENCY`=4 from cycle 5 → `mem_resp`=1 only in cycle 9, `mem_rdata`=0x0000, `mem_error`=0.
- Write 0xBEEF to 0x0020 with be=11, then write 0x12 with be=01 to 0x0020, then read 0x0020 → `mem_rdata`=0xBE12. Each access has exactly one `mem_resp` pulse, 4 cycles after acceptance.
- `MEM_WORDS`=256: write 0xA5A5 to 0x0202, read 0x0002 → 0xA5A5 (wrap). Write with be=00 to 0x0002, read again → still 0xA5A5.
- Write 0x1111 to 0x0040, then drop `mem_write` 2 cycles after acceptance → no `mem_resp`, FSM back in IDLE. A subsequent read of 0x0040 returns 0x0000.
- Assert `mem_read` and `mem_write` together at 0x0040 with wdata 0x7777 → `mem_resp`=`mem_error`=1 in cycle N+4. Word unchanged and `mem_rdata` unchanged from its prior value.
- Assert reset while a write is in BUSY → no `mem_resp`, all outputs 0 next cycle. A read of that address afterwards returns 0x0000. With `LATENCY`=1, a read gets `mem_resp` in cycle N+1.
